ram_rr_ctrl: RTL

- Multi-channel RAM controller with internal storage. It replaces the tristate, single-master RAM front-end with NUM_CH independent requesters.
- Each requester uses a valid/ready handshake. Arbitration between requesters is round-robin.
- Read data is registered and returns after 1 cycle, with a per-channel response strobe.
- A built-in clear engine zeroes the whole array after reset, and again on demand. It sits between the CPU datapath/DMA masters and the storage array.

---
 rtl/ram_rr_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/ram_rr_ctrl.sv
// ram_rr_ctrl: multi-channel RAM front-end with internal storage.
// NUM_CH requesters share one array through a round-robin arbiter. Reads
// return registered data one cycle after the grant. A clear engine zeroes
// the array after reset and whenever clear_req is pulsed while serving.
module ram_rr_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_CH        = 2
) (
    input  logic                            clk,
    input  logic                            n_rst,
    input  logic [NUM_CH-1:0]               req_valid,
    input  logic [NUM_CH-1:0]               req_wr,
    input  logic [NUM_CH*ADDRESS_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_CH-1:0]               req_ready,
    output logic [NUM_CH-1:0]               rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    input  logic                            clear_req,
    output logic                            busy
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [ADDRESS_WIDTH-1:0] clr_addr;
    logic [CH_W-1:0]          rr_ptr;
    logic [CH_W-1:0]          next_ptr;
    logic [CH_W-1:0]          grant_idx;
    logic                     grant_found;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_wdata;
    logic                     sel_wr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Next-state logic: the clear walks the whole array once, then serving
    // continues until a clear is requested.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (&clr_addr) begin
                    next_state = SERVE;
                end
            end
            SERVE: begin
                if (clear_req) begin
                    next_state = CLEAR;
                end
            end
            default: next_state = CLEAR;
        endcase
    end

    // Round-robin search: the first valid channel at or above rr_ptr wins.
    // A clear request suppresses every grant in its cycle.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        if (state == SERVE && !clear_req) begin
            for (int k = 0; k < NUM_CH; k++) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (!grant_found && req_valid[c] &&
                        (c == (int'(rr_ptr) + k) % NUM_CH)) begin
                        grant_found = 1'b1;
                        grant_idx   = CH_W'(c);
                    end
                end
            end
        end
    end

    // One-hot grant plus the payload of the granted channel.
    always_comb begin
        req_ready = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_found && grant_idx == CH_W'(c)) begin
                req_ready[c] = 1'b1;
                sel_addr     = req_addr[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                sel_wdata    = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
                sel_wr       = req_wr[c];
            end
        end
        next_ptr = CH_W'((int'(grant_idx) + 1) % NUM_CH);
    end

    // Control state: FSM, clear address walker and round-robin pointer.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            rr_ptr   <= '0;
        end else begin
            state <= next_state;
            if (state == CLEAR) begin
                clr_addr <= clr_addr + ADDRESS_WIDTH'(1);
            end else begin
                clr_addr <= '0;
            end
            if (grant_found) begin
                rr_ptr <= next_ptr;
            end
        end
    end

    // Storage array: the clear engine owns the write port while busy.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (grant_found && sel_wr) begin
            mem[sel_addr] <= sel_wdata;
        end
    end

    // Read response register: strobe for one cycle, data held until the next read.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= '0;
            if (grant_found && !sel_wr) begin
                rsp_valid <= req_ready;
                rsp_data  <= mem[sel_addr];
            end
        end
    end

endmodule
